// File: rtl/mpu_v2_if.sv
// Signal bundle for mpu_v2: update stream, memory read/write ports, MGU output
// and status. master = the update engine, slave = its environment.
interface mpu_v2_if #(
  parameter int VPROP_W = 32,
  parameter int EIDX_W  = 32,
  parameter int EDEG_W  = 32,
  parameter int ADDR_W  = 33,
  parameter int DATA_W  = 256
);
  logic [ADDR_W+VPROP_W-1:0]        upd_data;
  logic                             upd_valid;
  logic                             upd_ready;
  logic [1:0]                       mode;

  logic [ADDR_W-1:0]                rd_addr;
  logic                             rd_start;
  logic                             rd_done;
  logic [DATA_W-1:0]                rd_data;

  logic [ADDR_W-1:0]                wr_addr;
  logic [DATA_W-1:0]                wr_data;
  logic                             wr_start;
  logic                             wr_done;

  logic [VPROP_W+EIDX_W+EDEG_W-1:0] mgu_data;
  logic                             mgu_valid;
  logic                             mgu_ready;

  logic                             busy;
  logic [31:0]                      upd_count;
  logic [31:0]                      act_count;

  modport master (
    input  upd_data, upd_valid, mode, rd_done, rd_data, wr_done, mgu_ready,
    output upd_ready, rd_addr, rd_start, wr_addr, wr_data, wr_start,
           mgu_data, mgu_valid, busy, upd_count, act_count
  );

  modport slave (
    output upd_data, upd_valid, mode, rd_done, rd_data, wr_done, mgu_ready,
    input  upd_ready, rd_addr, rd_start, wr_addr, wr_data, wr_start,
           mgu_data, mgu_valid, busy, upd_count, act_count
  );
endinterface

// File: rtl/mpu_v2.sv
// Vertex property update unit: buffers {addr, value} messages, read-modify-writes
// the vertex word with a MIN/MAX/ADD reduction and forwards activations to the MGU.
module mpu_v2 #(
  parameter int VPROP_W     = 32,
  parameter int VPROP_START = 64,
  parameter int EIDX_W      = 32,
  parameter int EDEG_W      = 32,
  parameter int ADDR_W      = 33,
  parameter int DATA_W      = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input logic       clk,
  input logic       resetn,
  mpu_v2_if.master  bus
);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int MSG_W      = ADDR_W + VPROP_W;
  localparam int TEMP_START = VPROP_START + VPROP_W;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_READ_WAIT, S_REDUCE, S_DECIDE, S_WRITE, S_WRITE_WAIT, S_SEND
  } state_e;

  typedef enum logic [1:0] {M_OFF, M_MIN, M_MAX, M_ADD} mode_e;

  state_e state, state_nx;

  // ---------------- update FIFO ----------------
  logic [MSG_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_full, fifo_empty, push, pop;
  logic [MSG_W-1:0] head;

  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = bus.upd_valid && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; fifo_cnt alone
  // decides which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.upd_data;
  end

  // NOTE: every sequential update uses <= so all registers sample the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- transaction registers ----------------
  logic [ADDR_W-1:0]  addr_q;
  logic [VPROP_W-1:0] val_q;
  mode_e              mode_q;
  logic [DATA_W-1:0]  word_q;
  logic [VPROP_W-1:0] result_q;
  logic [EIDX_W-1:0]  eidx_q;
  logic [EDEG_W-1:0]  edeg_q;
  logic               wen_q, sen_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [31:0]        upd_cnt, act_cnt;

  // ---------------- reduction ----------------
  logic [VPROP_W-1:0] old_p, old_t, red_result, red_temp;
  logic [EIDX_W-1:0]  eidx;
  logic [EDEG_W-1:0]  edeg;
  logic               red_wen, red_sen;
  logic [DATA_W-1:0]  red_word;

  // NOTE: each always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    old_p      = word_q[VPROP_START +: VPROP_W];
    old_t      = word_q[TEMP_START +: VPROP_W];
    edeg       = word_q[0 +: EDEG_W];
    eidx       = word_q[EDEG_W +: EIDX_W];
    red_result = old_p;
    red_temp   = old_t;
    red_wen    = 1'b0;
    red_sen    = 1'b0;
    case (mode_q)
      M_MIN: begin
        if ((val_q < old_t) && (edeg != '0)) begin
          red_result = val_q;
          red_temp   = val_q;
          red_wen    = 1'b1;
          red_sen    = 1'b1;
        end
      end
      M_MAX: begin
        if ((val_q > old_t) && (edeg != '0)) begin
          red_result = val_q;
          red_temp   = val_q;
          red_wen    = 1'b1;
          red_sen    = 1'b1;
        end
      end
      M_ADD: begin
        // Accumulate into temp-prop only; prop is written back unchanged.
        red_temp = old_t + val_q;
        red_wen  = 1'b1;
      end
      default: ;
    endcase
    red_word = word_q;
    red_word[VPROP_START +: VPROP_W] = red_result;
    red_word[TEMP_START +: VPROP_W]  = red_temp;
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      val_q    <= '0;
      mode_q   <= M_OFF;
      word_q   <= '0;
      result_q <= '0;
      eidx_q   <= '0;
      edeg_q   <= '0;
      wen_q    <= 1'b0;
      sen_q    <= 1'b0;
      wdata_q  <= '0;
      upd_cnt  <= '0;
      act_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        addr_q <= head[MSG_W-1 -: ADDR_W];
        val_q  <= head[VPROP_W-1:0];
        mode_q <= mode_e'(bus.mode);
        if (upd_cnt != '1) upd_cnt <= upd_cnt + 32'd1;
      end
      if ((state == S_READ_WAIT) && bus.rd_done) word_q <= bus.rd_data;
      if (state == S_REDUCE) begin
        result_q <= red_result;
        eidx_q   <= eidx;
        edeg_q   <= edeg;
        wen_q    <= red_wen;
        sen_q    <= red_sen;
        wdata_q  <= red_word;
      end
      if ((state == S_SEND) && bus.mgu_ready && (act_cnt != '1)) act_cnt <= act_cnt + 32'd1;
    end
  end

  // ---------------- next state and strobes ----------------
  always_comb begin
    state_nx      = state;
    bus.rd_start  = 1'b0;
    bus.wr_start  = 1'b0;
    bus.mgu_valid = 1'b0;
    case (state)
      S_IDLE:       if (!fifo_empty) state_nx = S_READ;
      S_READ: begin
        bus.rd_start = 1'b1;
        state_nx     = S_READ_WAIT;
      end
      S_READ_WAIT:  if (bus.rd_done) state_nx = S_REDUCE;
      S_REDUCE:     state_nx = S_DECIDE;
      S_DECIDE:     state_nx = wen_q ? S_WRITE : S_IDLE;
      S_WRITE: begin
        bus.wr_start = 1'b1;
        state_nx     = S_WRITE_WAIT;
      end
      S_WRITE_WAIT: if (bus.wr_done) state_nx = sen_q ? S_SEND : S_IDLE;
      S_SEND: begin
        bus.mgu_valid = 1'b1;
        if (bus.mgu_ready) state_nx = S_IDLE;
      end
      default:      state_nx = S_IDLE;
    endcase
  end

  assign bus.upd_ready = !fifo_full;
  assign bus.rd_addr   = addr_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = wdata_q;
  assign bus.mgu_data  = {result_q, eidx_q, edeg_q};
  assign bus.busy      = (state != S_IDLE) || !fifo_empty;
  assign bus.upd_count = upd_cnt;
  assign bus.act_count = act_cnt;
endmodule

// File: tb/tb_mpu_v2.sv
// Self-checking bench for mpu_v2: vector table plus corner sequences, with a
// memory/MGU responder checking reads, writes and activations against queues.
module tb_mpu_v2;
  localparam int VPROP_W = 32;
  localparam int EIDX_W  = 32;
  localparam int EDEG_W  = 32;
  localparam int ADDR_W  = 33;
  localparam int DATA_W  = 256;
  localparam int NVEC    = 11;

  localparam logic [1:0] OFF = 2'b00, MIN = 2'b01, MAX = 2'b10, ADD = 2'b11;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mpu_v2_if #(.VPROP_W(VPROP_W), .EIDX_W(EIDX_W), .EDEG_W(EDEG_W),
              .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mpu_v2 #(.VPROP_W(VPROP_W), .VPROP_START(64), .EIDX_W(EIDX_W), .EDEG_W(EDEG_W),
           .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4))
    dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic [1:0]  mode;
    logic [32:0] addr;
    logic [31:0] nv, op, ot, ei, ed;
    bit          wen, sen;
    logic [31:0] res, tmp;
  } vec_t;

  typedef struct packed {
    logic [32:0]  a;
    logic [255:0] d;
  } wr_exp_t;

  int checks = 0;
  int failures = 0;

  logic [32:0]  rd_q[$];
  wr_exp_t      wr_q[$];
  logic [95:0]  mgu_q[$];
  logic [255:0] mem [logic [32:0]];

  bit rd_stall = 0, wr_stall = 0, mgu_hold = 0;
  int rd_seen = 0, wr_seen = 0, mgu_seen = 0;
  int exp_upd = 0, exp_act = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [255:0] act);
    checks++;
    failures++;
    $display("FAIL unexpected_%s: got %0h required none", name, act);
  endtask

  function automatic logic [255:0] make_word(input logic [255:0] f, input logic [31:0] p,
                                             input logic [31:0] t, input logic [31:0] ei,
                                             input logic [31:0] ed);
    logic [255:0] w;
    w = f;
    w[63:0]   = {ei, ed};
    w[95:64]  = p;
    w[127:96] = t;
    return w;
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input logic [32:0] a, input logic [31:0] nv,
                              input logic [31:0] op, input logic [31:0] ot, input logic [31:0] ei,
                              input logic [31:0] ed, input bit we, input bit se,
                              input logic [31:0] r, input logic [31:0] tm);
    vec_t v;
    v.mode = m; v.addr = a; v.nv = nv; v.op = op; v.ot = ot; v.ei = ei; v.ed = ed;
    v.wen = we; v.sen = se; v.res = r; v.tmp = tm;
    return v;
  endfunction

  // Preload memory and queue the reads/writes/activations this message must cause.
  task automatic expect_vec(input vec_t v);
    logic [255:0] f;
    wr_exp_t e;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = $urandom;
    mem[v.addr] = make_word(f, v.op, v.ot, v.ei, v.ed);
    rd_q.push_back(v.addr);
    if (v.wen) begin
      e.a = v.addr;
      e.d = make_word(f, v.res, v.tmp, v.ei, v.ed);
      wr_q.push_back(e);
    end
    if (v.sen) begin
      mgu_q.push_back({v.res, v.ei, v.ed});
      exp_act++;
    end
    exp_upd++;
  endtask

  // Called at a negedge; returns at the negedge after the message was accepted.
  task automatic push_msg(input logic [32:0] a, input logic [31:0] v);
    int n;
    n = 0;
    bus.upd_data  = {a, v};
    bus.upd_valid = 1'b1;
    while (!bus.upd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) unexpected("push_timeout", a);
    @(negedge clk);
    bus.upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus.busy || rd_q.size() != 0 || wr_q.size() != 0 || mgu_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) unexpected({tag, "_idle_timeout"}, n);
  endtask

  // Memory and MGU responder: checks every DUT request against the queues.
  initial begin
    bit rd_pend, wr_pend;
    int rd_tmr, wr_tmr;
    logic [32:0] rd_a;
    wr_exp_t e;
    logic [95:0] m;
    rd_pend = 0; wr_pend = 0; rd_tmr = 0; wr_tmr = 0; rd_a = '0;
    bus.rd_done = 1'b0; bus.wr_done = 1'b0; bus.rd_data = '0; bus.mgu_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.rd_done   = 1'b0;
      bus.wr_done   = 1'b0;
      bus.mgu_ready = !mgu_hold;
      if (resetn) begin
        if (bus.rd_start) begin
          rd_seen++;
          if (rd_q.size() == 0) unexpected("read", bus.rd_addr);
          else check("rd_addr", bus.rd_addr, rd_q.pop_front());
          rd_a = bus.rd_addr; rd_pend = 1; rd_tmr = 2;
        end else if (rd_pend && !rd_stall) begin
          if (rd_tmr == 0) begin
            bus.rd_data = mem.exists(rd_a) ? mem[rd_a] : '0;
            bus.rd_done = 1'b1;
            rd_pend = 0;
          end else rd_tmr--;
        end
        if (bus.wr_start) begin
          wr_seen++;
          if (wr_q.size() == 0) unexpected("write", bus.wr_addr);
          else begin
            e = wr_q.pop_front();
            check("wr_addr", bus.wr_addr, e.a);
            check("wr_data", bus.wr_data, e.d);
          end
          mem[bus.wr_addr] = bus.wr_data;
          wr_pend = 1; wr_tmr = 1;
        end else if (wr_pend && !wr_stall) begin
          if (wr_tmr == 0) begin
            bus.wr_done = 1'b1;
            wr_pend = 0;
          end else wr_tmr--;
        end
        if (bus.mgu_valid && bus.mgu_ready) begin
          mgu_seen++;
          if (mgu_q.size() == 0) unexpected("mgu", bus.mgu_data);
          else begin
            m = mgu_q.pop_front();
            check("mgu_data", bus.mgu_data, m);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[NVEC];
    vec_t s;
    int rd0, mgu0, wr0, n;

    vecs[0]  = mk(MIN, 33'h10,        32'd5,        32'd7,      32'd9,        32'h40,       32'd3,        1, 1, 32'd5,        32'd5);
    vecs[1]  = mk(MIN, 33'h11,        32'd9,        32'd7,      32'd5,        32'h41,       32'd3,        0, 0, 32'd0,        32'd0);
    vecs[2]  = mk(ADD, 33'h12,        32'd2,        32'h1234,   32'hFFFFFFFF, 32'h42,       32'd0,        1, 0, 32'h1234,     32'd1);
    vecs[3]  = mk(MAX, 33'h13,        32'd20,       32'd3,      32'd10,       32'd7,        32'd1,        1, 1, 32'd20,       32'd20);
    vecs[4]  = mk(MAX, 33'h14,        32'd10,       32'd3,      32'd10,       32'd7,        32'd1,        0, 0, 32'd0,        32'd0);
    vecs[5]  = mk(MIN, 33'h15,        32'd1,        32'd3,      32'd2,        32'd7,        32'd0,        0, 0, 32'd0,        32'd0);
    vecs[6]  = mk(OFF, 33'h16,        32'd1,        32'd3,      32'd2,        32'd7,        32'd5,        0, 0, 32'd0,        32'd0);
    vecs[7]  = mk(MIN, 33'h17,        32'h80000000, 32'd3,      32'h7FFFFFFF, 32'd7,        32'd1,        0, 0, 32'd0,        32'd0);
    vecs[8]  = mk(MIN, 33'h1_0000_0018, 32'd1,      32'hDEAD,   32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'd1,        32'd1);
    vecs[9]  = mk(ADD, 33'h19,        32'd3,        32'h55,     32'd4,        32'd1,        32'd9,        1, 0, 32'h55,       32'd7);
    vecs[10] = mk(MAX, 33'h1A,        32'hFFFFFFFF, 32'd0,      32'hFFFFFFFE, 32'd3,        32'd2,        1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);

    bus.upd_valid = 1'b0;
    bus.upd_data  = '0;
    bus.mode      = OFF;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    check("rst_upd_ready", bus.upd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_start", bus.rd_start, 0);
    check("rst_wr_start", bus.wr_start, 0);
    check("rst_mgu_valid", bus.mgu_valid, 0);
    check("rst_upd_count", bus.upd_count, 0);
    check("rst_act_count", bus.act_count, 0);

    // Table-driven single messages.
    for (int i = 0; i < NVEC; i++) begin
      rd0 = rd_seen;
      bus.mode = vecs[i].mode;
      expect_vec(vecs[i]);
      push_msg(vecs[i].addr, vecs[i].nv);
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d_reads", i), rd_seen - rd0, 1);
      check($sformatf("v%0d_upd_count", i), bus.upd_count, exp_upd);
      check($sformatf("v%0d_act_count", i), bus.act_count, exp_act);
    end

    // Back-to-back pushes while stalled in READ_WAIT; queued messages take the
    // mode in force when they are popped, not when they were pushed.
    bus.mode = MIN;
    rd_stall = 1;
    rd0 = rd_seen;
    expect_vec(mk(MIN, 33'h200, 32'd3, 32'd1, 32'd8, 32'h11, 32'd1, 1, 1, 32'd3, 32'd3));
    push_msg(33'h200, 32'd3);
    n = 0;
    while (rd_seen == rd0 && n < 100) begin @(negedge clk); n++; end
    check("stall_read_issued", rd_seen - rd0, 1);
    expect_vec(mk(MAX, 33'h201, 32'd9,   32'd1, 32'd4,   32'h12, 32'd2, 1, 1, 32'd9,  32'd9));
    expect_vec(mk(MAX, 33'h202, 32'd1,   32'd1, 32'd4,   32'h13, 32'd2, 0, 0, 32'd0,  32'd0));
    expect_vec(mk(MAX, 33'h203, 32'd50,  32'd1, 32'd49,  32'h14, 32'd1, 1, 1, 32'd50, 32'd50));
    expect_vec(mk(MAX, 33'h204, 32'd7,   32'd1, 32'd7,   32'h15, 32'd1, 0, 0, 32'd0,  32'd0));
    push_msg(33'h201, 32'd9);
    push_msg(33'h202, 32'd1);
    push_msg(33'h203, 32'd50);
    check("fifo_ready_before_full", bus.upd_ready, 1);
    push_msg(33'h204, 32'd7);
    check("fifo_full_ready", bus.upd_ready, 0);
    check("fifo_full_busy", bus.busy, 1);
    bus.mode = MAX;
    rd_stall = 0;
    expect_vec(mk(MAX, 33'h205, 32'd100, 32'd1, 32'd0, 32'h16, 32'd4, 1, 1, 32'd100, 32'd100));
    push_msg(33'h205, 32'd100);
    wait_idle("burst");
    check("burst_upd_count", bus.upd_count, exp_upd);
    check("burst_act_count", bus.act_count, exp_act);

    // MGU back-pressure: data held stable, FIFO still accepting.
    bus.mode = MIN;
    mgu_hold = 1;
    s = mk(MIN, 33'h300, 32'd2, 32'd1, 32'd6, 32'h99, 32'd4, 1, 1, 32'd2, 32'd2);
    expect_vec(s);
    push_msg(s.addr, s.nv);
    n = 0;
    while (!bus.mgu_valid && n < 100) begin @(negedge clk); n++; end
    mgu0 = mgu_seen;
    check("hold_upd_ready", bus.upd_ready, 1);
    expect_vec(mk(MIN, 33'h301, 32'd9, 32'd1, 32'd1, 32'h9A, 32'd1, 0, 0, 32'd0, 32'd0));
    push_msg(33'h301, 32'd9);
    check("hold_push_busy", bus.busy, 1);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold%0d_mgu_valid", c), bus.mgu_valid, 1);
      check($sformatf("hold%0d_mgu_data", c), bus.mgu_data, {32'd2, 32'h99, 32'd4});
      @(negedge clk);
    end
    check("hold_no_transfer", mgu_seen - mgu0, 0);
    mgu_hold = 0;
    wait_idle("hold");
    check("hold_transfer", mgu_seen - mgu0, 1);
    check("hold_upd_count", bus.upd_count, exp_upd);
    check("hold_act_count", bus.act_count, exp_act);

    // Reset during WRITE_WAIT with two messages queued; the late wr_done is ignored.
    bus.mode = MIN;
    wr_stall = 1;
    wr0 = wr_seen;
    s = mk(MIN, 33'h400, 32'd1, 32'd1, 32'd9, 32'h77, 32'd1, 1, 1, 32'd1, 32'd1);
    expect_vec(s);
    void'(mgu_q.pop_back());
    push_msg(33'h400, 32'd1);
    push_msg(33'h401, 32'd1);
    push_msg(33'h402, 32'd1);
    n = 0;
    while (wr_seen == wr0 && n < 100) begin @(negedge clk); n++; end
    check("ww_write_issued", wr_seen - wr0, 1);
    check("ww_busy", bus.busy, 1);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_upd = 0;
    exp_act = 0;
    @(negedge clk);
    check("rst2_upd_ready", bus.upd_ready, 1);
    check("rst2_busy", bus.busy, 0);
    check("rst2_rd_start", bus.rd_start, 0);
    check("rst2_wr_start", bus.wr_start, 0);
    check("rst2_mgu_valid", bus.mgu_valid, 0);
    check("rst2_rd_addr", bus.rd_addr, 0);
    check("rst2_wr_addr", bus.wr_addr, 0);
    check("rst2_wr_data", bus.wr_data, 0);
    check("rst2_mgu_data", bus.mgu_data, 0);
    check("rst2_upd_count", bus.upd_count, 0);
    check("rst2_act_count", bus.act_count, 0);
    rd0 = rd_seen;
    wr0 = wr_seen;
    wr_stall = 0;
    repeat (10) @(negedge clk);
    check("late_busy", bus.busy, 0);
    check("late_mgu_valid", bus.mgu_valid, 0);
    check("late_no_read", rd_seen - rd0, 0);
    check("late_no_write", wr_seen - wr0, 0);
    check("late_act_count", bus.act_count, 0);

    // Normal operation after reset.
    rd0 = rd_seen;
    expect_vec(mk(MIN, 33'h500, 32'd4, 32'd1, 32'd6, 32'h21, 32'd2, 1, 1, 32'd4, 32'd4));
    push_msg(33'h500, 32'd4);
    wait_idle("post");
    check("post_reads", rd_seen - rd0, 1);
    check("post_upd_count", bus.upd_count, exp_upd);
    check("post_act_count", bus.act_count, exp_act);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
